// File: rtl/mem_pkg.sv
// Shared types and parameter defaults for the mem register bank.
package mem_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_NUM_REGS   = 16;
  localparam int unsigned DEFAULT_NUM_INPUTS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } write_state_t;

endpackage

// File: rtl/mem_write_fsm.sv
// Write handshake controller: accept in IDLE, commit in WRITE, pulse ack in ACK.
module mem_write_fsm
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic write_en,
  output logic write_rdy,
  output logic write_ack,
  output logic capture_c,
  output logic commit_c
);

  write_state_t state_q;
  write_state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // write_en is only looked at in IDLE, so requests during a write are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (write_en) state_d = WRITE;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // write_rdy/write_ack come from state only; capture_c is the one input-qualified strobe
  always_comb begin
    write_rdy = 1'b0;
    write_ack = 1'b0;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      IDLE: begin
        write_rdy = 1'b1;
        capture_c = write_en;
      end
      WRITE:   commit_c  = 1'b1;
      ACK:     write_ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem.sv
// Register bank with staged write handshake and an on_off-gated registered read path.
module mem
  import mem_pkg::*;
#(
  parameter int unsigned width      = DEFAULT_WIDTH,
  parameter int unsigned num_regs   = DEFAULT_NUM_REGS,
  parameter int unsigned num_inputs = DEFAULT_NUM_INPUTS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_off,
  input  logic             write_en,
  input  logic [width-1:0] w_data_in [num_inputs:0],
  output logic             write_rdy,
  output logic             write_ack,
  output logic [width-1:0] r_data_out [num_inputs:0],
  output logic             on_off_vector_fu
);

  generate
    if (num_regs < num_inputs + 1) begin : g_bad_params
      $error("mem: num_regs must be at least num_inputs+1");
    end
  endgenerate

  logic capture_c;
  logic commit_c;

  // Registers above num_inputs have no write port and are constant zero, so only
  // the lane-mapped registers are built.
  logic [width-1:0] staging [num_inputs:0];
  logic [width-1:0] regs    [num_inputs:0];

  mem_write_fsm u_write_fsm (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_rdy (write_rdy),
    .write_ack (write_ack),
    .capture_c (capture_c),
    .commit_c  (commit_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(num_inputs); i++) staging[i] <= '0;
    end else if (capture_c) begin
      staging <= w_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(num_inputs); i++) regs[i] <= '0;
    end else if (commit_c) begin
      regs <= staging;
    end
  end

  // Read samples pre-commit contents on a shared edge, so new data lands a cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(num_inputs); i++) r_data_out[i] <= '0;
      on_off_vector_fu <= 1'b0;
    end else begin
      if (on_off) r_data_out <= regs;
      on_off_vector_fu <= on_off;
    end
  end

endmodule

// File: tb/tb_mem.sv
// Randomized scoreboard bench for mem against a cycle-level behavioural model.
module tb_mem;

  localparam int unsigned W  = 16;
  localparam int unsigned NI = 8;
  localparam int unsigned NL = NI + 1;

  typedef logic [NL-1:0][W-1:0] vec_t;
  typedef struct packed {
    logic rdy;
    logic ack;
    logic ofu;
  } status_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         on_off = 1'b0;
  logic         write_en = 1'b0;
  logic [W-1:0] w_data_in [NI:0];
  logic         write_rdy;
  logic         write_ack;
  logic [W-1:0] r_data_out [NI:0];
  logic         on_off_vector_fu;

  mem #(.width(W), .num_regs(16), .num_inputs(NI)) dut (
    .clk              (clk),
    .reset            (reset),
    .on_off           (on_off),
    .write_en         (write_en),
    .w_data_in        (w_data_in),
    .write_rdy        (write_rdy),
    .write_ack        (write_ack),
    .r_data_out       (r_data_out),
    .on_off_vector_fu (on_off_vector_fu)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  status_t st_q[$];
  vec_t    rd_q[$];

  // Model: register contents, staged data, and edges elapsed since a write was accepted
  vec_t regs_m;
  vec_t staged_m;
  int   phase_m = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input vec_t d, input logic oo);
    status_t s;
    @(negedge clk);
    reset    = r;
    write_en = we;
    on_off   = oo;
    for (int i = 0; i < int'(NL); i++) w_data_in[i] = d[i];
    if (r) begin
      regs_m   = '0;
      staged_m = '0;
      phase_m  = -1;
    end
    @(posedge clk);
    if (r) begin
      s = '{rdy: 1'b1, ack: 1'b0, ofu: 1'b0};
    end else begin
      if (oo) rd_q.push_back(regs_m);
      if (phase_m == -1) begin
        if (we) begin
          staged_m = d;
          phase_m  = 0;
        end
      end else if (phase_m == 0) begin
        regs_m  = staged_m;
        phase_m = 1;
      end else begin
        phase_m = -1;
      end
      s = '{rdy: (phase_m == -1), ack: (phase_m == 1), ofu: oo};
    end
    st_q.push_back(s);
  endtask

  task automatic idle(input int n, input logic oo);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, oo);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < int'(NL); i++) v[i] = W'($urandom);
    return v;
  endfunction

  // Monitor: per-cycle status, plus read data whenever the FU enable shows a load happened
  initial begin : monitor
    vec_t    hold;
    status_t s;
    int      bad;
    hold = '0;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("write_rdy", 32'(write_rdy), 32'(s.rdy));
        chk("write_ack", 32'(write_ack), 32'(s.ack));
        chk("on_off_vector_fu", 32'(on_off_vector_fu), 32'(s.ofu));
        if (write_ack) ack_seen++;
        if (reset) hold = '0;
        if (on_off_vector_fu) begin
          if (rd_q.size() == 0) begin
            chk("read_unexpected", 32'(1), 32'(0));
          end else begin
            hold = rd_q.pop_front();
          end
        end
        bad = -1;
        for (int i = 0; i < int'(NL); i++)
          if (bad < 0 && r_data_out[i] !== hold[i]) bad = i;
        if (bad >= 0) chk($sformatf("r_data_out[%0d]", bad), 32'(r_data_out[bad]), 32'(hold[bad]));
        else chk("r_data_out", 32'(0), 32'(0 + (bad >= 0)));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    vec_t v;
    int   a0;
    for (int i = 0; i < int'(NL); i++) w_data_in[i] = '0;
    regs_m   = '0;
    staged_m = '0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    for (int i = 0; i < int'(NL); i++) v[i] = W'(10 * i);
    step(1'b0, 1'b1, v, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    for (int i = 0; i < int'(NL); i++) v[i] = 16'hFFFF;
    step(1'b0, 1'b1, v, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    step(1'b0, 1'b1, rand_vec(), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    a0 = ack_seen;
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, rand_vec(), 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("acks_in_9_cycles", 32'(ack_seen - a0), 32'(3));

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), rand_vec(), 1'($urandom));
    end
    idle(3, 1'b1);
    idle(1, 1'b0);
    #2;
    chk("status_queue_drained", 32'(st_q.size()), 32'(0));
    chk("read_queue_drained", 32'(rd_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
